load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 18 +
 rtl/load_store_unit_if.sv | 25 ++
 rtl/lsu_lane_align.sv | 25 ++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: funct3 encodings, FSM state enum and latched request struct shared by the load/store unit and its bench
package lsu_pkg;
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } lsu_req_t;
  function automatic logic f3_legal(input logic [2:0] f);
    return f inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU};
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request (valid/ready), response (valid/ready) and word-memory bus; master = requester/memory side, slave = unit side
interface load_store_unit_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_wdata, mem_we
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational load extract/extend (load_data) and SB/SH merge into a fetched word (merged); inputs funct3, lane, word, wdata
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    load_data = funct3 == LSU_B  ? {{24{b[7]}}, b} :
                funct3 == LSU_H  ? {{16{h[15]}}, h} :
                funct3 == LSU_BU ? {24'b0, b} :
                funct3 == LSU_HU ? {16'b0, h} : word;
    merged = word;
    if (funct3 == LSU_H) merged[{lane[1], 4'b0000} +: 16] = wdata;
    else merged[{lane, 3'b000} +: 8] = wdata[7:0];
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V load/store initiator; clk, rst (sync active-low), bus = request/response handshake plus word-memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 10
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  lsu_state_t        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d, resp_rdata_q, resp_rdata_d;
  logic              mem_we_q, mem_we_d, resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
  logic              req_ready_q, req_ready_d;
  logic [31:0]       load_data, merged;
  logic              bad;
  assign bad = !f3_legal(bus.req_funct3)
             | (bus.req_we & bus.req_funct3[2])
             | ((bus.req_funct3 == LSU_H || bus.req_funct3 == LSU_HU) & bus.req_addr[0])
             | ((bus.req_funct3 == LSU_W) & |bus.req_addr[1:0])
             | |bus.req_addr[31:ADDR_W+2];
  lsu_lane_align u_align (
    .funct3   (req_q.funct3),
    .lane     (req_q.lane),
    .word     (bus.mem_rdata),
    .wdata    (req_q.wdata),
    .load_data(load_data),
    .merged   (merged)
  );
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        req_d = '{bus.req_we, bus.req_funct3, bus.req_addr[1:0], bus.req_wdata[15:0]};
        if (bad) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          mem_addr_d = bus.req_addr[ADDR_W+1:2];
          if (bus.req_we && bus.req_funct3 == LSU_W) begin
            mem_wdata_d = bus.req_wdata;
            mem_we_d    = 1'b1;
            state_d     = WRITE;
          end else begin
            cnt_d   = 3'(READ_LATENCY);
            state_d = READ;
          end
        end
      end
      READ: if (cnt_q != '0) cnt_d = cnt_q - 3'd1;
      else if (req_q.we) begin
        mem_wdata_d = merged;
        mem_we_d    = 1'b1;
        state_d     = WRITE;
      end else begin
        resp_rdata_d = load_data;
        resp_error_d = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      WRITE: begin
        resp_rdata_d = '0;
        resp_error_d = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: if (bus.resp_ready) begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      req_ready_q  <= req_ready_d;
    end
  end
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized check of two load_store_unit instances (READ_LATENCY 1 and 3) against a word-memory reference model
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_f3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] rd1;
  logic [31:0] p3 [3];
  int          n_vec = 0, n_miss = 0;
  always #5 clk = ~clk;
  load_store_unit_if #(.ADDR_W(10)) bus1 ();
  load_store_unit_if #(.ADDR_W(10)) bus3 ();
  load_store_unit #(.READ_LATENCY(1), .ADDR_W(10)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  load_store_unit #(.READ_LATENCY(3), .ADDR_W(10)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
  assign bus1.req_valid  = req_valid & !sel;
  assign bus3.req_valid  = req_valid & sel;
  assign bus1.req_we     = req_we;
  assign bus3.req_we     = req_we;
  assign bus1.req_funct3 = req_f3;
  assign bus3.req_funct3 = req_f3;
  assign bus1.req_addr   = req_addr;
  assign bus3.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;
  assign bus3.req_wdata  = req_wdata;
  assign bus1.resp_ready = resp_ready;
  assign bus3.resp_ready = resp_ready;
  assign bus1.mem_rdata  = rd1;
  assign bus3.mem_rdata  = p3[2];
  logic        o_req_ready, o_resp_valid, o_resp_error, o_mem_we;
  logic [31:0] o_resp_rdata, o_mem_wdata;
  logic [9:0]  o_mem_addr;
  assign o_req_ready  = sel ? bus3.req_ready  : bus1.req_ready;
  assign o_resp_valid = sel ? bus3.resp_valid : bus1.resp_valid;
  assign o_resp_error = sel ? bus3.resp_error : bus1.resp_error;
  assign o_resp_rdata = sel ? bus3.resp_rdata : bus1.resp_rdata;
  assign o_mem_we     = sel ? bus3.mem_we     : bus1.mem_we;
  assign o_mem_addr   = sel ? bus3.mem_addr   : bus1.mem_addr;
  assign o_mem_wdata  = sel ? bus3.mem_wdata  : bus1.mem_wdata;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (bus1.mem_we) mem[bus1.mem_addr] <= bus1.mem_wdata;
    if (bus3.mem_we) mem[bus3.mem_addr] <= bus3.mem_wdata;
    rd1   <= mem[bus1.mem_addr];
    p3[0] <= mem[bus3.mem_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (sel=%0d addr=%h f3=%0d we=%0d)", tag, got, exp, sel, req_addr, req_f3, req_we);
    end
  endtask
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input int rl,
                       output logic err, output logic [31:0] rdata, output int lat, output logic wr, output logic [31:0] nw);
    logic [31:0] w, byt, half;
    int sh, hs;
    logic legal;
    w     = ref_mem[a[11:2]];
    sh    = int'(a[1:0]) * 8;
    hs    = int'(a[1]) * 16;
    byt   = (w >> sh) & 32'hFF;
    half  = (w >> hs) & 32'hFFFF;
    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) && !(we && f3 >= 4);
    err   = !legal || ((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a[1:0] != 0) || a >= 32'h1000;
    rdata = 0;
    wr    = 0;
    nw    = w;
    lat   = 1;
    if (!err && we) begin
      wr  = 1;
      lat = f3 == 2 ? 2 : rl + 3;
      nw  = f3 == 2 ? wd :
            f3 == 0 ? (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh) :
                      (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
    end else if (!err) begin
      lat   = rl + 2;
      rdata = f3 == 0 ? (byt >= 128 ? byt | 32'hFFFF_FF00 : byt) :
              f3 == 1 ? (half >= 32768 ? half | 32'hFFFF_0000 : half) :
              f3 == 4 ? byt :
              f3 == 5 ? half : w;
    end
  endtask
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic err, wr;
    logic [31:0] er, nw, wdat;
    logic [9:0] wa;
    int lat, cyc, nwe;
    model(we, f3, a, wd, sel ? 3 : 1, err, er, lat, wr, nw);
    for (int i = 0; i < 20 && !o_req_ready; i++) @(negedge clk);
    check("req_ready_idle", o_req_ready, 1);
    req_valid = 1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 0;
    cyc = 1; nwe = 0; wa = '0; wdat = '0;
    while (1) begin
      if (o_mem_we) begin nwe++; wa = o_mem_addr; wdat = o_mem_wdata; end
      if (o_resp_valid || cyc >= 40) break;
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, lat);
    check("resp_rdata", o_resp_rdata, er);
    check("resp_error", o_resp_error, err);
    check("we_pulses", nwe, wr);
    if (wr) begin
      check("wr_addr", wa, a[11:2]);
      check("wr_data", wdat, nw);
      ref_mem[a[11:2]] = nw;
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_we = 1; req_f3 = 3'b010;
      req_addr = {22'b0, 10'($urandom_range(0, 1023)) & 10'h0FC}; req_wdata = $urandom;
      @(negedge clk);
      check("busy_req_ready", o_req_ready, 0);
      check("hold_valid", o_resp_valid, 1);
      check("hold_rdata", o_resp_rdata, er);
      check("hold_error", o_resp_error, err);
      check("hold_we", o_mem_we, 0);
    end
    req_valid = 0; resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    check("resp_done", o_resp_valid, 0);
    check("req_ready_back", o_req_ready, 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, o_req_ready, 1);
    check({tag, "_resp_valid"}, o_resp_valid, 0);
    check({tag, "_resp_rdata"}, o_resp_rdata, 0);
    check({tag, "_resp_error"}, o_resp_error, 0);
    check({tag, "_mem_addr"}, o_mem_addr, 0);
    check({tag, "_mem_wdata"}, o_mem_wdata, 0);
    check({tag, "_mem_we"}, o_mem_we, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [31:0] v, a;
    logic [2:0] f3;
    logic we;
    int w;
    for (int i = 0; i < 1024; i++) begin
      v = i == 5 ? 32'h80F1_7F22 : $urandom;
      @(negedge clk);
      ld_en = 1; ld_addr = 10'(i); ld_data = v; ref_mem[i] = v;
    end
    @(negedge clk);
    ld_en = 0;
    @(negedge clk);
    sel = 0; check_reset_outputs("reset");
    sel = 1; check_reset_outputs("reset3");
    sel = 0;
    rst = 1;
    @(negedge clk);
    do_req(0, 3'b000, 32'h17, 0, 0);
    do_req(0, 3'b100, 32'h17, 0, 0);
    do_req(0, 3'b001, 32'h14, 0, 0);
    do_req(0, 3'b010, 32'h14, 0, 0);
    do_req(1, 3'b000, 32'h15, 32'hAAAA_AA5C, 0);
    check("sb_merged_word", mem[5], 32'h80F1_5C22);
    do_req(0, 3'b010, 32'h16, 0, 0);
    do_req(1, 3'b001, 32'h13, 32'h1111_2222, 0);
    do_req(0, 3'b010, 32'h1000, 0, 0);
    do_req(1, 3'b010, 32'hFFC, 32'h1234_5678, 0);
    do_req(0, 3'b010, 32'h14, 0, 5);
    req_valid = 1; req_we = 1; req_f3 = 3'b001; req_addr = 32'h14; req_wdata = 32'h0000_BEEF;
    @(negedge clk);
    req_valid = 0;
    rst = 0;
    @(negedge clk);
    rst = 1;
    check_reset_outputs("midop");
    check("midop_mem_kept", mem[5], ref_mem[5]);
    do_req(0, 3'b010, 32'h14, 0, 0);
    sel = 1;
    do_req(0, 3'b010, 32'h14, 0, 0);
    do_req(1, 3'b000, 32'h15, 32'h0000_0033, 0);
    do_req(0, 3'b010, 32'h14, 0, 1);
    for (int n = 0; n < 200; n++) begin
      sel = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) f3 = $urandom_range(0, 2) == 0 ? 3'b011 : $urandom_range(0, 1) ? 3'b110 : 3'b111;
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        w  = $urandom_range(0, 4);
        f3 = w == 3 ? 3'b100 : w == 4 ? 3'b101 : 3'(w);
      end
      w = $urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(1008, 1023);
      a = {20'b0, 10'(w), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      do_req(we, f3, a, $urandom, $urandom_range(0, 3));
    end
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
